adder_arbiter: RTL and testbench

- Shares one n-bit adder between NREQ requesters (e.g. PC increment, branch-target calc, address gen) with round-robin arbitration.
- Each requester uses a valid/ready handshake and presents two operands. The winner's sum is registered and returned with the winner's ID on a single result channel with its own valid/ready handshake.
- The block contains the adder datapath, the grant logic and a one-entry result register.

---
 rtl/adder_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_adder_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Purpose:
//    Shares a single n-bit adder between NREQ requesters. Each requester offers
//    an operand pair over a valid/ready handshake. A round-robin arbiter picks
//    one requester per cycle. The winner's sum, carry and ID are written into a
//    one-entry result register. That register drains through a valid/ready
//    result channel.
//
// Ports:
//    clk        clock, all state changes on the rising edge
//    rst        synchronous active-high reset
//    req_valid  [NREQ]     per-requester operand-valid
//    req_ready  [NREQ]     per-requester operand-taken (one-hot or zero)
//    req_a      [NREQ*n]   packed operand A, requester i at [i*n +: n]
//    req_b      [NREQ*n]   packed operand B, same packing
//    res_valid             result register holds an unconsumed result
//    res_ready             consumer takes the result this cycle
//    res_data   [n]        (a+b) mod 2^n of the granted pair
//    res_cout              carry out of the n-bit add
//    res_id     [IDW]      index of the requester that produced res_data
// -----------------------------------------------------------------------------
`ifndef WORDSIZE
`define WORDSIZE 32
`endif

module adder_arbiter #(
   parameter int n    = `WORDSIZE,
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*n-1:0] req_a,
   input  logic [NREQ*n-1:0] req_b,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [n-1:0]      res_data,
   output logic              res_cout,
   output logic [IDW-1:0]    res_id
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_t         state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [n-1:0]   data_q, data_d;
   logic           cout_q, cout_d;
   logic [IDW-1:0] id_q, id_d;

   // ---------------------------------------------------------------------------
   // Operand unpacking
   // ---------------------------------------------------------------------------
   logic [n-1:0] op_a [NREQ];
   logic [n-1:0] op_b [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign op_a[gi] = req_a[gi*n +: n];
      assign op_b[gi] = req_b[gi*n +: n];
   end

   // Index 'base + k' wrapped modulo NREQ. base < NREQ and k < NREQ, so one
   // conditional subtract replaces the modulo. This also works when NREQ is
   // not a power of two.
   function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) begin
         s = s - NREQ;
      end
      return IDW'(s);
   endfunction

   // ---------------------------------------------------------------------------
   // Round-robin search: the first valid requester at or after ptr_q wins.
   // ---------------------------------------------------------------------------
   logic           win_found;
   logic [IDW-1:0] win_idx;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!win_found && req_valid[rr_index(ptr_q, k)]) begin
            win_found = 1'b1;
            win_idx   = rr_index(ptr_q, k);
         end
      end
   end

   // The register can take a new result when it is empty, or when it is
   // emptied in this same cycle. Reset blocks all grants.
   logic can_accept;
   logic accept;

   assign can_accept = !rst && ((state_q == ST_EMPTY) || res_ready);
   assign accept     = win_found && can_accept;

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Shared adder. It is one bit wider than the operands so that the top bit
   // carries out.
   // ---------------------------------------------------------------------------
   logic [n:0] sum_full;

   assign sum_full = {1'b0, op_a[win_idx]} + {1'b0, op_b[win_idx]};

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      data_d  = data_q;
      cout_d  = cout_q;
      id_d    = id_q;

      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_FULL;
            end
         end
         ST_FULL: begin
            // An accept while full implies res_ready=1. The old result is
            // consumed and replaced without a bubble.
            if (!accept && res_ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      if (accept) begin
         data_d = sum_full[n-1:0];
         cout_d = sum_full[n];
         id_d   = win_idx;
         ptr_d  = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         ptr_q   <= '0;
         data_q  <= '0;
         cout_q  <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         data_q  <= data_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
      end
   end

   assign res_valid = (state_q == ST_FULL);
   assign res_data  = data_q;
   assign res_cout  = cout_q;
   assign res_id    = id_q;

   // ---------------------------------------------------------------------------
   // Protocol properties
   // ---------------------------------------------------------------------------
   a_ready_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));

   a_ready_needs_valid : assert property (@(posedge clk) (req_ready & ~req_valid) == '0);

   a_stall_stable : assert property (@(posedge clk) disable iff (rst)
      (res_valid && !res_ready) |=> ($stable(res_data) && $stable(res_cout) && $stable(res_id)));

   a_stall_no_grant : assert property (@(posedge clk)
      (res_valid && !res_ready) |-> (req_ready == '0));

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Directed scenarios for adder_arbiter with n=32 and NREQ=4. The expected
// values are worked out by hand from the round-robin rules. Inputs change 2 ns
// after a rising edge. Outputs are sampled before the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_adder_arbiter;

   localparam int N    = 32;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic              res_valid;
   logic              res_ready;
   logic [N-1:0]      res_data;
   logic              res_cout;
   logic [IDW-1:0]    res_id;

   int n_cmp  = 0;
   int n_fail = 0;

   adder_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_cout  (res_cout),
      .res_id    (res_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One line per consumed result.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         $display("[%0t] result consumed: id=%0d data=%h cout=%0d", $time, res_id, res_data, res_cout);
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
      req_a[i*N +: N] = a;
      req_b[i*N +: N] = b;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      rst = 1'b1; req_valid = 4'b0001; res_ready = 1'b0;
      req_a = '0; req_b = '0;
      repeat (2) @(posedge clk);
      #2;
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", res_valid); end
      n_cmp++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", res_data); end
      n_cmp++; if (res_cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %0b expected 0", res_cout); end
      n_cmp++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d expected 0", res_id); end
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
      rst = 1'b0; req_valid = '0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_single();
      set_op(0, 32'd5, 32'd7);
      req_valid = 4'b0001; res_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant: got %b expected 0001", req_ready); end
      cyc();
      req_valid = '0;
      n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", res_valid); end
      n_cmp++; if (res_data !== 32'd12) begin n_fail++; $display("FAIL single_data: got %0d expected 12", res_data); end
      n_cmp++; if (res_cout !== 1'b0) begin n_fail++; $display("FAIL single_cout: got %0b expected 0", res_cout); end
      n_cmp++; if (res_id !== 2'd0) begin n_fail++; $display("FAIL single_id: got %0d expected 0", res_id); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_round_robin();
      logic [3:0] exp_rdy;
      // Start from ptr=0.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'd1, 32'd1);
      req_valid = 4'b1111; res_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_rdy = 4'b0001 << (k % 4);
         #1;
         n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", k, req_ready, exp_rdy); end
         cyc();
         n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d]: got %0b expected 1", k, res_valid); end
         n_cmp++; if (res_id !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_id[%0d]: got %0d expected %0d", k, res_id, k % 4); end
         n_cmp++; if (res_data !== 32'd2) begin n_fail++; $display("FAIL rr_data[%0d]: got %0d expected 2", k, res_data); end
      end
      req_valid = '0;
      // ptr is now 1. The result from req 0 is still pending.
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_carry();
      set_op(2, 32'hFFFF_FFFF, 32'h0000_0001);
      req_valid = 4'b0100;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL carry_grant: got %b expected 0100", req_ready); end
      cyc();
      req_valid = '0;
      n_cmp++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL carry_data: got %h expected 00000000", res_data); end
      n_cmp++; if (res_cout !== 1'b1) begin n_fail++; $display("FAIL carry_cout: got %0b expected 1", res_cout); end
      n_cmp++; if (res_id !== 2'd2) begin n_fail++; $display("FAIL carry_id: got %0d expected 2", res_id); end
      // ptr is now 3.
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_backpressure();
      set_op(1, 32'd10, 32'd20);
      req_valid = 4'b0010;
      #1;
      // The search starts at 3, wraps to 0, then finds 1.
      n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_first: got %b expected 0010", req_ready); end
      cyc();
      set_op(0, 32'd3, 32'd4);
      set_op(2, 32'd100, 32'd200);
      req_valid = 4'b0101; res_ready = 1'b0;
      n_cmp++; if (res_id !== 2'd1 || res_data !== 32'd30) begin n_fail++; $display("FAIL bp_pending: got id=%0d data=%0d expected id=1 data=30", res_id, res_data); end
      for (int j = 0; j < 3; j++) begin
         #1;
         n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0000", j, req_ready); end
         cyc();
         n_cmp++; if (res_valid !== 1'b1 || res_id !== 2'd1 || res_data !== 32'd30) begin n_fail++; $display("FAIL bp_stall_hold[%0d]: got v=%0b id=%0d data=%0d expected v=1 id=1 data=30", j, res_valid, res_id, res_data); end
      end
      res_ready = 1'b1;
      #1;
      n_cmp++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_grant: got %b expected 0100", req_ready); end
      cyc();
      n_cmp++; if (res_id !== 2'd2 || res_data !== 32'd300) begin n_fail++; $display("FAIL bp_res2: got id=%0d data=%0d expected id=2 data=300", res_id, res_data); end
      #1;
      n_cmp++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_next_grant: got %b expected 0001", req_ready); end
      cyc();
      req_valid = '0;
      n_cmp++; if (res_id !== 2'd0 || res_data !== 32'd7) begin n_fail++; $display("FAIL bp_res0: got id=%0d data=%0d expected id=0 data=7", res_id, res_data); end
      // ptr is now 1. The result from req 0 is pending.
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_mid();
      res_ready = 1'b0;
      cyc();
      n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pending: got %0b expected 1", res_valid); end
      set_op(3, 32'd50, 32'd60);
      rst = 1'b1; req_valid = 4'b1010;
      #1;
      n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rm_ready_in_rst: got %b expected 0000", req_ready); end
      cyc();
      rst = 1'b0;
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid_cleared: got %0b expected 0", res_valid); end
      n_cmp++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL rm_data_cleared: got %h expected 0", res_data); end
      #1;
      n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_first_grant: got %b expected 0010", req_ready); end
      cyc();
      res_ready = 1'b1;
      n_cmp++; if (res_id !== 2'd1 || res_data !== 32'd30) begin n_fail++; $display("FAIL rm_res1: got id=%0d data=%0d expected id=1 data=30", res_id, res_data); end
      #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rm_second_grant: got %b expected 1000", req_ready); end
      cyc();
      req_valid = '0;
      n_cmp++; if (res_id !== 2'd3 || res_data !== 32'd110) begin n_fail++; $display("FAIL rm_res3: got id=%0d data=%0d expected id=3 data=110", res_id, res_data); end
      // ptr is now 0.
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_idle();
      for (int j = 0; j < 5; j++) begin
         cyc();
         n_cmp++; if (res_valid !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle[%0d]: got v=%0b rdy=%b expected v=0 rdy=0000", j, res_valid, req_ready); end
      end
      set_op(1, 32'd8, 32'd9);
      set_op(2, 32'd1000, 32'd2000);
      req_valid = 4'b0110;
      #1;
      // ptr is unchanged at 0, so req 1 wins ahead of req 2.
      n_cmp++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL idle_ptr_grant: got %b expected 0010", req_ready); end
      cyc();
      set_op(3, 32'h8000_0000, 32'h8000_0001);
      req_valid = 4'b1000;
      n_cmp++; if (res_id !== 2'd1 || res_data !== 32'd17) begin n_fail++; $display("FAIL idle_res1: got id=%0d data=%0d expected id=1 data=17", res_id, res_data); end
      #1;
      n_cmp++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL idle_single_grant: got %b expected 1000", req_ready); end
      cyc();
      req_valid = '0;
      n_cmp++; if (res_id !== 2'd3 || res_data !== 32'd1 || res_cout !== 1'b1) begin n_fail++; $display("FAIL idle_res3: got id=%0d data=%h cout=%0b expected id=3 data=00000001 cout=1", res_id, res_data, res_cout); end
      cyc();
      n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL idle_drain: got %0b expected 0", res_valid); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_carry();
      test_backpressure();
      test_reset_mid();
      test_idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
